// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage
// Instruction Fetch stage plus IF/ID pipeline register feeding Instruction_Decode.
// Holds the PC, drives the fetch address, and captures the fetched word together
// with its PC+4 for decode. Applies branch redirects and hazard stalls from decode.
// Optional feature: define IF_PERF_COUNT_EN to add the FetchCount/StallCount
// performance counters (ports and registers are absent otherwise).
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        PCSel,
    input  logic [31:0] BranchPC,
    input  logic        Stall_PC,
    input  logic        Stall_ID,
    input  logic [31:0] InstrData,
    output logic [31:0] InstrAddr,
    output logic [31:0] Instruction_ID,
    output logic [31:0] PCPlusFour_ID,
    output logic        Valid_ID,
`ifdef IF_PERF_COUNT_EN
    output logic [31:0] FetchCount,
    output logic [31:0] StallCount,
`endif
    output logic [0:0]  state_dbg
);

    // Two-state sequencer: one BOOT cycle after reset, then RUN forever.
    localparam logic [0:0] BOOT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    // There is no valid/ready handshake in this stage: flow control is the
    // stall pair from decode. Valid_ID=1 marks a real instruction in IF/ID,
    // Valid_ID=0 marks a bubble (NOP_WORD with PCPlusFour_ID=0); decode must
    // treat a bubble as doing nothing.

    logic [0:0]  state_q;
    logic [0:0]  state_d;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] pc_plus_four;
    logic [31:0] redirect_pc;
    logic        id_load;
    logic        id_bubble;

    // Sequential PC arithmetic wraps naturally at 2^32.
    assign pc_plus_four = pc_q + 32'd4;
    // Branch targets are forced word aligned.
    assign redirect_pc  = BranchPC & ~32'h0000_0003;
    assign InstrAddr    = pc_q;
    assign state_dbg    = state_q;

    // Next-state, next-PC and IF/ID update selection.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        id_load   = 1'b0;
        id_bubble = 1'b0;
        case (state_q)
            BOOT: begin
                // Stall and redirect inputs are ignored until RUN.
                state_d   = RUN;
                pc_d      = RESET_PC;
                id_bubble = 1'b1;
            end
            RUN: begin
                state_d = RUN;
                // A redirect is not taken while the PC is stalled: the branch
                // operands are not ready yet, decode will re-present it.
                if (Stall_PC) begin
                    pc_d = pc_q;
                end else if (PCSel) begin
                    pc_d = redirect_pc;
                end else begin
                    pc_d = pc_plus_four;
                end
                // Stall_ID holds IF/ID even in the (illegal) case where the PC
                // still advances; the PC path above is independent of it.
                if (Stall_ID) begin
                    id_load   = 1'b0;
                    id_bubble = 1'b0;
                end else if (Stall_PC || PCSel) begin
                    // PC-only stall, or a taken branch squashing the
                    // wrong-path word (no delay slot).
                    id_bubble = 1'b1;
                end else begin
                    id_load = 1'b1;
                end
            end
            default: begin
                state_d   = BOOT;
                pc_d      = RESET_PC;
                id_bubble = 1'b1;
            end
        endcase
    end

    // State and PC registers; reset wins over every other input.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // IF/ID pipeline register: load the fetched word, insert a bubble, or hold.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Instruction_ID <= NOP_WORD;
            PCPlusFour_ID  <= 32'd0;
            Valid_ID       <= 1'b0;
        end else if (id_load) begin
            Instruction_ID <= InstrData;
            PCPlusFour_ID  <= pc_plus_four;
            Valid_ID       <= 1'b1;
        end else if (id_bubble) begin
            Instruction_ID <= NOP_WORD;
            PCPlusFour_ID  <= 32'd0;
            Valid_ID       <= 1'b0;
        end
    end

`ifdef IF_PERF_COUNT_EN
    logic stall_event;

    // A stall cycle is any RUN edge with the PC held.
    assign stall_event = (state_q == RUN) && Stall_PC;

    // Saturating count of instructions delivered to decode.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            FetchCount <= 32'd0;
        end else if (id_load && (FetchCount != 32'hFFFF_FFFF)) begin
            FetchCount <= FetchCount + 32'd1;
        end
    end

    // Saturating count of PC stall cycles.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            StallCount <= 32'd0;
        end else if (stall_event && (StallCount != 32'hFFFF_FFFF)) begin
            StallCount <= StallCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed scenarios from the feature list
// plus randomized stall/redirect/reset traffic against a behavioural model.
module tb_instruction_fetch_stage;

    // ---------------- clock / reset ----------------
    logic Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic        Reset;
    logic        PCSel;
    logic [31:0] BranchPC;
    logic        Stall_PC;
    logic        Stall_ID;

    logic [31:0] InstrAddr, InstrData, Instruction_ID, PCPlusFour_ID;
    logic        Valid_ID;
    logic [0:0]  state_dbg;
    logic [31:0] w_addr, w_data, w_instr, w_pc4;
    logic        w_valid;
    logic [0:0]  w_state;
`ifdef IF_PERF_COUNT_EN
    logic [31:0] FetchCount, StallCount, w_fetch_cnt, w_stall_cnt;
`endif

    // Instruction memory: word(A) = A + 0x1000, combinational read.
    assign InstrData = InstrAddr + 32'h1000;
    assign w_data    = w_addr + 32'h1000;

    instruction_fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_WORD(32'h0000_0000)) dut (
        .Clock(Clock), .Reset(Reset), .PCSel(PCSel), .BranchPC(BranchPC),
        .Stall_PC(Stall_PC), .Stall_ID(Stall_ID), .InstrData(InstrData),
        .InstrAddr(InstrAddr), .Instruction_ID(Instruction_ID),
        .PCPlusFour_ID(PCPlusFour_ID), .Valid_ID(Valid_ID),
`ifdef IF_PERF_COUNT_EN
        .FetchCount(FetchCount), .StallCount(StallCount),
`endif
        .state_dbg(state_dbg)
    );

    instruction_fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_WORD(32'h0000_0000)) u_wrap (
        .Clock(Clock), .Reset(Reset), .PCSel(PCSel), .BranchPC(BranchPC),
        .Stall_PC(Stall_PC), .Stall_ID(Stall_ID), .InstrData(w_data),
        .InstrAddr(w_addr), .Instruction_ID(w_instr),
        .PCPlusFour_ID(w_pc4), .Valid_ID(w_valid),
`ifdef IF_PERF_COUNT_EN
        .FetchCount(w_fetch_cnt), .StallCount(w_stall_cnt),
`endif
        .state_dbg(w_state)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic drive_idle();
        PCSel    = 1'b0;
        BranchPC = 32'h0;
        Stall_PC = 1'b0;
        Stall_ID = 1'b0;
    endtask

    task automatic reset_and_release();
        drive_idle();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
    endtask

    // ---------------- directed scenarios ----------------
    task automatic test_reset();
        drive_idle();
        Reset = 1'b1;
        tick();
        tick();
        checks++; if (InstrAddr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected %h", InstrAddr, 32'h0); end
        checks++; if (Valid_ID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", Valid_ID); end
        checks++; if (Instruction_ID !== 32'h0 || PCPlusFour_ID !== 32'h0) begin errors++; $display("FAIL reset_ifid: got %h/%h expected 0/0", Instruction_ID, PCPlusFour_ID); end
        checks++; if (state_dbg !== 1'b0) begin errors++; $display("FAIL reset_state: got %b expected 0", state_dbg); end
`ifdef IF_PERF_COUNT_EN
        checks++; if (FetchCount !== 32'h0 || StallCount !== 32'h0) begin errors++; $display("FAIL reset_counters: got %h/%h expected 0/0", FetchCount, StallCount); end
`endif
        Reset = 1'b0;
        tick(); // BOOT edge
        checks++; if (Valid_ID !== 1'b0 || InstrAddr !== 32'h0 || state_dbg !== 1'b1) begin errors++; $display("FAIL boot_edge: got v=%b addr=%h st=%b expected v=0 addr=0 st=1", Valid_ID, InstrAddr, state_dbg); end
        exp_q.push_back(32'h1000);
        exp_q.push_back(32'h1004);
        for (int i = 0; i < 2; i++) begin
            logic [31:0] e;
            tick();
            e = exp_q.pop_front();
            checks++; if (Instruction_ID !== e || PCPlusFour_ID !== e - 32'h1000 + 32'd4 || Valid_ID !== 1'b1) begin
                errors++; $display("FAIL seq_fetch%0d: got %h/%h/%b expected %h/%h/1", i, Instruction_ID, PCPlusFour_ID, Valid_ID, e, e - 32'h1000 + 32'd4);
            end
        end
        checks++; if (InstrAddr !== 32'h8) begin errors++; $display("FAIL seq_pc: got %h expected %h", InstrAddr, 32'h8); end
    endtask

    task automatic test_branch();
        // PC is 8 here
        PCSel = 1'b1; BranchPC = 32'h0000_0043;
        tick();
        checks++; if (InstrAddr !== 32'h40) begin errors++; $display("FAIL branch_pc: got %h expected %h", InstrAddr, 32'h40); end
        checks++; if (Instruction_ID !== 32'h0 || Valid_ID !== 1'b0) begin errors++; $display("FAIL branch_bubble: got %h/%b expected 0/0", Instruction_ID, Valid_ID); end
        PCSel = 1'b0; BranchPC = 32'h0;
        tick();
        checks++; if (Instruction_ID !== 32'h1040 || PCPlusFour_ID !== 32'h44 || Valid_ID !== 1'b1) begin errors++; $display("FAIL branch_target: got %h/%h/%b expected 1040/44/1", Instruction_ID, PCPlusFour_ID, Valid_ID); end
    endtask

    task automatic test_stall();
        reset_and_release();
        for (int i = 0; i < 5; i++) tick(); // BOOT + fetches of 0,4,8,12
        checks++; if (InstrAddr !== 32'h10 || Instruction_ID !== 32'h100C) begin errors++; $display("FAIL stall_setup: got %h/%h expected 10/100c", InstrAddr, Instruction_ID); end
        Stall_PC = 1'b1; Stall_ID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (InstrAddr !== 32'h10 || Instruction_ID !== 32'h100C || PCPlusFour_ID !== 32'h10 || Valid_ID !== 1'b1) begin
                errors++; $display("FAIL stall_hold%0d: got %h %h/%h/%b expected 10 100c/10/1", i, InstrAddr, Instruction_ID, PCPlusFour_ID, Valid_ID);
            end
        end
`ifdef IF_PERF_COUNT_EN
        checks++; if (StallCount !== 32'd3 || FetchCount !== 32'd4) begin errors++; $display("FAIL stall_counters: got %0d/%0d expected 3/4", StallCount, FetchCount); end
`endif
        drive_idle();
        tick();
        checks++; if (Instruction_ID !== 32'h1010 || PCPlusFour_ID !== 32'h14 || Valid_ID !== 1'b1) begin errors++; $display("FAIL stall_resume: got %h/%h/%b expected 1010/14/1", Instruction_ID, PCPlusFour_ID, Valid_ID); end
`ifdef IF_PERF_COUNT_EN
        checks++; if (FetchCount !== 32'd5) begin errors++; $display("FAIL resume_fetchcount: got %0d expected 5", FetchCount); end
`endif
    endtask

    task automatic test_stall_branch();
        // PC is 0x14 here
        Stall_PC = 1'b1; Stall_ID = 1'b0; PCSel = 1'b1; BranchPC = 32'h80;
        tick();
        checks++; if (InstrAddr !== 32'h14) begin errors++; $display("FAIL stallbr_pc: got %h expected %h", InstrAddr, 32'h14); end
        checks++; if (Instruction_ID !== 32'h0 || PCPlusFour_ID !== 32'h0 || Valid_ID !== 1'b0) begin errors++; $display("FAIL stallbr_bubble: got %h/%h/%b expected 0/0/0", Instruction_ID, PCPlusFour_ID, Valid_ID); end
        drive_idle();
        tick();
        checks++; if (Instruction_ID !== 32'h1014 || PCPlusFour_ID !== 32'h18 || Valid_ID !== 1'b1) begin errors++; $display("FAIL stallbr_resume: got %h/%h/%b expected 1014/18/1", Instruction_ID, PCPlusFour_ID, Valid_ID); end
    endtask

    task automatic test_reset_mid();
        PCSel = 1'b1; BranchPC = 32'h200; Reset = 1'b1;
        tick();
        checks++; if (InstrAddr !== 32'h0 || Valid_ID !== 1'b0 || state_dbg !== 1'b0) begin errors++; $display("FAIL midreset: got addr=%h v=%b st=%b expected 0/0/0", InstrAddr, Valid_ID, state_dbg); end
`ifdef IF_PERF_COUNT_EN
        checks++; if (FetchCount !== 32'h0 || StallCount !== 32'h0) begin errors++; $display("FAIL midreset_counters: got %h/%h expected 0/0", FetchCount, StallCount); end
`endif
        drive_idle();
        Reset = 1'b0;
        tick(); // BOOT edge: redirect must not survive reset
        checks++; if (InstrAddr !== 32'h0) begin errors++; $display("FAIL midreset_boot_pc: got %h expected 0", InstrAddr); end
    endtask

    task automatic test_wrap();
        reset_and_release();
        tick(); // BOOT
        checks++; if (w_addr !== 32'hFFFF_FFFC || w_valid !== 1'b0) begin errors++; $display("FAIL wrap_boot: got %h/%b expected fffffffc/0", w_addr, w_valid); end
        tick();
        checks++; if (w_instr !== 32'h0000_0FFC || w_pc4 !== 32'h0 || w_valid !== 1'b1) begin errors++; $display("FAIL wrap_first: got %h/%h/%b expected ffc/0/1", w_instr, w_pc4, w_valid); end
        checks++; if (w_addr !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h expected 0", w_addr); end
        tick();
        checks++; if (w_instr !== 32'h1000 || w_pc4 !== 32'h4) begin errors++; $display("FAIL wrap_second: got %h/%h expected 1000/4", w_instr, w_pc4); end
    endtask

    // ---------------- randomized traffic vs reference model ----------------
    task automatic test_random();
        logic        m_run;
        logic [31:0] m_pc, m_instr, m_pc4, m_fetch, m_stall;
        logic        m_valid;
        reset_and_release();
        m_run = 1'b0; m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        m_fetch = 32'h0; m_stall = 32'h0;
        for (int n = 0; n < 400; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            Stall_PC = (r < 30);
            Stall_ID = Stall_PC ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
            PCSel    = ($urandom_range(0, 3) == 0);
            BranchPC = $urandom_range(0, 32'h0000_0FFF);
            Reset    = ($urandom_range(0, 59) == 0);
            // expected result of this edge
            if (Reset) begin
                m_run = 1'b0; m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
                m_fetch = 32'h0; m_stall = 32'h0;
            end else if (!m_run) begin
                m_run = 1'b1; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
            end else begin
                if (Stall_PC && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
                if (!Stall_ID) begin
                    if (Stall_PC || PCSel) begin
                        m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
                    end else begin
                        m_instr = m_pc + 32'h1000; m_pc4 = m_pc + 4; m_valid = 1'b1;
                        if (m_fetch != 32'hFFFF_FFFF) m_fetch = m_fetch + 1;
                    end
                end
                if (!Stall_PC) m_pc = PCSel ? {BranchPC[31:2], 2'b00} : m_pc + 4;
            end
            exp_q.push_back(m_instr);
            tick();
            begin
                logic [31:0] e;
                e = exp_q.pop_front();
                checks++; if (Instruction_ID !== e || PCPlusFour_ID !== m_pc4 || Valid_ID !== m_valid) begin
                    errors++; $display("FAIL rand_ifid[%0d]: got %h/%h/%b expected %h/%h/%b", n, Instruction_ID, PCPlusFour_ID, Valid_ID, e, m_pc4, m_valid);
                end
                checks++; if (InstrAddr !== m_pc || state_dbg !== m_run) begin
                    errors++; $display("FAIL rand_pc[%0d]: got %h st=%b expected %h st=%b", n, InstrAddr, state_dbg, m_pc, m_run);
                end
`ifdef IF_PERF_COUNT_EN
                checks++; if (FetchCount !== m_fetch || StallCount !== m_stall) begin
                    errors++; $display("FAIL rand_counters[%0d]: got %0d/%0d expected %0d/%0d", n, FetchCount, StallCount, m_fetch, m_stall);
                end
`endif
            end
        end
        Reset = 1'b0;
        drive_idle();
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        Reset = 1'b1;
        drive_idle();
        test_reset();
        test_branch();
        test_stall();
        test_stall_branch();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

Instruction Fetch stage plus IF/ID pipeline register, directly upstream of the Instruction_Decode stage. Holds the PC, presents the fetch address to the external instruction memory, and captures the fetched word and PC+4 for decode. Applies the branch redirect (PCSel/BranchPC) and the stall signals (Stall_PC/Stall_ID) that decode produces. Inserts bubbles on taken branches and on PC-only stalls.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; low 2 bits must be 0
- NOP_WORD, 32'h0000_0000, instruction word driven into IF/ID for a bubble

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- PCSel  in  1  from ID: redirect PC to BranchPC
- BranchPC  in  32  from ID: redirect target
- Stall_PC  in  1  from ID hazard detection: hold PC
- Stall_ID  in  1  from ID hazard detection: hold IF/ID register
- InstrData  in  32  instruction memory read data (combinational read of InstrAddr)
- InstrAddr  out  32  fetch address, equals PC
- Instruction_ID  out  32  IF/ID instruction to decode
- PCPlusFour_ID  out  32  IF/ID PC+4 of that instruction
- Valid_ID  out  1  IF/ID holds a real instruction (0 = bubble)
- FetchCount  out  32  only with IF_PERF_COUNT_EN
- StallCount  out  32  only with IF_PERF_COUNT_EN

## Operation
- FSM, 2 states: BOOT, RUN. Reset -> BOOT. BOOT -> RUN unconditionally next cycle. RUN stays RUN until Reset.
- BOOT: PC held at RESET_PC, IF/ID loads bubble (NOP_WORD, PCPlusFour_ID=0, Valid_ID=0). Stall/PCSel ignored.
- RUN, PC update priority: Stall_PC=1 -> hold; else PCSel=1 -> {BranchPC[31:2],2'b00}; else PC+4.
- PC arithmetic mod 2^32; PC+4 from 32'hFFFF_FFFC wraps to 0, no flag.
- RUN, IF/ID update priority: Stall_ID=1 -> hold all three fields; else Stall_PC=1 -> bubble; else PCSel=1 -> bubble (wrong-path word squashed, no delay slot); else load InstrData, PC+4, Valid_ID=1.
- PCSel is ignored while Stall_PC=1 (branch operands not ready).
- Stall_ID=1 with Stall_PC=0 is illegal from decode; the block must still hold IF/ID and advance the PC as listed (no assertion required).

## Timing
- Reset values: PC=RESET_PC, InstrAddr=RESET_PC, Instruction_ID=NOP_WORD, PCPlusFour_ID=0, Valid_ID=0, counters 0, state BOOT.
- InstrAddr is combinational from PC register; InstrData sampled at the same rising edge that advances PC.
- Latency: word at address A appears on Instruction_ID one cycle after PC=A, with PCPlusFour_ID=A+4.
- Redirect: PCSel sampled high at edge N -> PC=target after N; target instruction valid in ID after N+1; one bubble cycle between.
- First valid instruction reaches ID two edges after Reset deasserts (BOOT cycle + fetch cycle).
- Reset mid-operation overrides all inputs on that edge; pending redirect discarded.

## Configuration
- IF_PERF_COUNT_EN defined: FetchCount increments on every edge that loads Valid_ID=1; StallCount increments on every RUN edge with Stall_PC=1; both saturate at 32'hFFFF_FFFF; cleared by Reset.
- Undefined: FetchCount/StallCount ports and counter registers absent; all other behaviour identical.

## Test plan
- Reset, RESET_PC=0, memory word(A)=A+32'h1000, no stalls -> edge 2 after reset: Instruction_ID=32'h1000, PCPlusFour_ID=4, Valid_ID=1; then 32'h1004/8, 32'h1008/12.
- PCSel=1, BranchPC=32'h0000_0043 while PC=8 -> PC=32'h40 next edge, Instruction_ID=NOP_WORD, Valid_ID=0 one cycle, then word(0x40) with PCPlusFour_ID=32'h44.
- Stall_PC=1, Stall_ID=1 for 3 cycles at PC=16 -> PC and IF/ID unchanged 3 cycles; StallCount +3 (macro on); resume fetches word(16).
- Stall_PC=1, Stall_ID=0, PCSel=1 same cycle -> PC held, IF/ID bubble, redirect ignored.
- RESET_PC=32'hFFFF_FFFC, run 2 fetches -> PCPlusFour_ID=0 for first instruction, PC wraps to 0.
- Reset asserted mid-redirect -> next edge PC=RESET_PC, Valid_ID=0, counters 0, BOOT.
